tt_sweep_checker: RTL and testbench



---
 rtl/tt_sweep_checker.sv | 98 +++++++++
 tb/tb_tt_sweep_checker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: drives every input pattern into a small combinational DUT and checks its output against a truth table
// Ports: clk, rst_n (async active-low); start requests a sweep and is honoured only when idle;
// dut_out is the DUT response and dut_in the pattern driven to it; busy is high while sweeping, done pulses at the end;
// pass, err_cnt, err_valid and first_err_idx report the last sweep and hold until the next accepted start.
module tt_sweep_checker #(
  parameter int N_IN = 2,
  parameter logic [2**N_IN-1:0] EXPECT = 4'b0110,
  parameter int HOLD = 1,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            err_valid,
  output logic [N_IN-1:0] first_err_idx
);
  localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;
  state_e          state_q;
  logic [N_IN-1:0] idx_q, dut_in_q, first_err_idx_q;
  logic [HW-1:0]   hold_q;
  logic [N_IN:0]   err_cnt_q;
  logic            busy_q, done_q, pass_q, err_valid_q, mism;
  assign mism = dut_out != EXPECT[idx_q];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      hold_q          <= '0;
      dut_in_q        <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_cnt_q       <= '0;
      err_valid_q     <= 1'b0;
      first_err_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q         <= DRIVE;
            idx_q           <= '0;
            hold_q          <= '0;
            dut_in_q        <= '0;
            busy_q          <= 1'b1;
            pass_q          <= 1'b0;
            err_cnt_q       <= '0;
            err_valid_q     <= 1'b0;
            first_err_idx_q <= '0;
          end
        end
        DRIVE: begin
          if (hold_q == HW'(HOLD - 1)) begin
            if (mism) begin
              err_cnt_q <= err_cnt_q + (N_IN + 1)'(1);
              if (!err_valid_q) begin
                err_valid_q     <= 1'b1;
                first_err_idx_q <= idx_q;
              end
            end
            // the terminal test comes before any increment, so idx never wraps
            if (&idx_q || (mism && STOP_ON_ERR)) begin
              state_q  <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              dut_in_q <= '0;
              pass_q   <= err_cnt_q == '0 && !mism;
            end else begin
              idx_q    <= idx_q + N_IN'(1);
              dut_in_q <= idx_q + N_IN'(1);
              hold_q   <= '0;
            end
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
  assign dut_in        = dut_in_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign err_valid     = err_valid_q;
  assign first_err_idx = first_err_idx_q;
endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb_tt_sweep_checker: three checker configurations sharing start/reset, each compared every cycle against a sweep-trace model
module tb_tt_sweep_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int fsel = 0;
  logic [255:0] rnd_tab = '0;
  int tot_m = 0, bad_m = 0, total, bad;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : c
    localparam int N = g == 2 ? 3 : 2;
    localparam int NP = 2 ** N;
    localparam int H = g == 2 ? 3 : 1;
    localparam bit S = g == 1;
    localparam logic [NP-1:0] EX = NP'(g == 2 ? 8'h96 : 8'h06);
    logic [N-1:0] dut_in, first_err_idx;
    logic [N:0] err_cnt;
    logic busy, done, pass, err_valid, dut_out;
    logic [NP-1:0] fn, tab = '0;
    int n = 0, len, firstm, tot = 0, bad = 0;
    bit started = 1'b0;

    tt_sweep_checker #(.N_IN(N), .EXPECT(EX), .HOLD(H), .STOP_ON_ERR(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
      .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .err_valid(err_valid), .first_err_idx(first_err_idx)
    );

    // circuit under test: the table loaded when a sweep is accepted
    assign dut_out = tab[dut_in];

    always_comb begin
      fn = '0;
      for (int p = 0; p < NP; p++) begin
        logic [7:0] v;
        v = 8'(p);
        fn[p] = fsel == 0 ? ^v : fsel == 1 ? &v[N-1:0] : rnd_tab[p];
      end
    end

    // sweep length in cycles follows from the loaded table alone
    always_comb begin
      firstm = -1;
      for (int p = 0; p < NP; p++) if (firstm < 0 && tab[p] != EX[p]) firstm = p;
      len = ((S && firstm >= 0) ? firstm + 1 : NP) * H;
    end

    // n = clock edges since the accepting edge, saturating one past the done cycle
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        started <= 1'b0;
        n <= 0;
      end else if (start && (!started || n > len)) begin
        started <= 1'b1;
        n <= 0;
        tab <= fn;
      end else if (started && n <= len) n <= n + 1;
    end

    task automatic ck(string nm, int a, int e);
      tot++;
      if (a != e) begin
        bad++;
        $display("FAIL cfg%0d %s got=%0d want=%0d t=%0t", g, nm, a, e, $time);
      end
    endtask

    always @(negedge clk) begin
      int k, cnt, fi;
      if (rst_n) begin
        k = !started ? 0 : n < len ? n / H : len / H;
        cnt = 0;
        fi = -1;
        for (int p = 0; p < k; p++) if (tab[p] != EX[p]) begin
          cnt++;
          if (fi < 0) fi = p;
        end
        ck("dut_in", int'(dut_in), started && n < len ? n / H : 0);
        ck("busy", int'(busy), int'(started && n < len));
        ck("done", int'(done), int'(started && n == len));
        ck("pass", int'(pass), int'(started && n >= len && cnt == 0));
        ck("err_cnt", int'(err_cnt), cnt);
        ck("err_valid", int'(err_valid), int'(cnt > 0));
        ck("first_err_idx", int'(first_err_idx), fi < 0 ? 0 : fi);
      end
    end
  end

  task automatic lit(string nm, int a, int e);
    tot_m++;
    if (a != e) begin
      bad_m++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  initial begin
    int b2, d0;
    bit hit2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lit("rst_din", int'(c[0].dut_in), 0);
    lit("rst_busy", int'(c[0].busy), 0);
    lit("rst_pass", int'(c[0].pass), 0);
    lit("rst_cnt", int'(c[0].err_cnt), 0);
    // XOR / parity: everything matches
    fsel = 0;
    pulse();
    b2 = 0;
    for (int n = 0; n < 30; n++) begin
      if (n < 4) lit("xor_din", int'(c[0].dut_in), n);
      if (n == 4) begin
        lit("xor_done", int'(c[0].done), 1);
        lit("xor_pass", int'(c[0].pass), 1);
        lit("xor_cnt", int'(c[0].err_cnt), 0);
        lit("xor_valid", int'(c[0].err_valid), 0);
      end
      if (n < 24 && n % 3 == 1) lit("par_hold", int'(c[2].dut_in), n / 3);
      if (n == 26) begin
        lit("par_pass", int'(c[2].pass), 1);
        lit("par_cnt", int'(c[2].err_cnt), 0);
      end
      b2 += int'(c[2].busy);
      @(negedge clk);
    end
    lit("par_busy_cycles", b2, 24);
    // AND: mismatches at 1,2,3; start re-pulsed while busy
    fsel = 1;
    pulse();
    d0 = 0;
    hit2 = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (n == 1) start = 1'b1;
      if (n == 2) start = 1'b0;
      if (n == 2) lit("stop_done", int'(c[1].done), 1);
      if (c[1].busy && c[1].dut_in >= 2) hit2 = 1'b1;
      d0 += int'(c[0].done);
      @(negedge clk);
    end
    lit("and_done_once", d0, 1);
    lit("and_cnt", int'(c[0].err_cnt), 3);
    lit("and_first", int'(c[0].first_err_idx), 1);
    lit("and_valid", int'(c[0].err_valid), 1);
    lit("and_pass", int'(c[0].pass), 0);
    lit("stop_cnt", int'(c[1].err_cnt), 1);
    lit("stop_first", int'(c[1].first_err_idx), 1);
    lit("stop_pass", int'(c[1].pass), 0);
    lit("stop_no_pat2", int'(hit2), 0);
    // new start clears previous count; async reset mid-sweep
    fsel = 0;
    pulse();
    lit("clr_cnt", int'(c[0].err_cnt), 0);
    repeat (2) @(negedge clk);
    lit("pre_rst_din", int'(c[0].dut_in), 2);
    #2 rst_n = 1'b0;
    #1;
    lit("arst_din", int'(c[0].dut_in), 0);
    lit("arst_busy", int'(c[0].busy), 0);
    lit("arst_busy2", int'(c[2].busy), 0);
    lit("arst_valid1", int'(c[1].err_valid), 0);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    lit("post_rst_busy", int'(c[0].busy), 0);
    pulse();
    lit("restart_din", int'(c[0].dut_in), 0);
    lit("restart_busy", int'(c[0].busy), 1);
    repeat (4) @(negedge clk);
    lit("restart_done", int'(c[0].done), 1);
    lit("restart_pass", int'(c[0].pass), 1);
    // randomized tables, start traffic and occasional async resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      fsel = $urandom_range(0, 2);
      for (int j = 0; j < 8; j++) rnd_tab[j*32 +: 32] = $urandom;
      start = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    total = tot_m + c[0].tot + c[1].tot + c[2].tot;
    bad = bad_m + c[0].bad + c[1].bad + c[2].bad;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
